// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: read-side drain stage of the dual-clock FIFO (clk_rd domain).
// Issues rd_en against fifo_empty_rd, absorbs the FIFO's fixed read latency
// (non-show-ahead) and re-presents the data as a valid/ready stream through a
// credit-controlled skid buffer. Accepted beats are counted per frame and the
// FRAME_LEN-th beat of every frame is flagged with m_last.
//
// Ports:
//   clk_rd, rst_rd_n   read-domain clock, async active-low reset
//   fifo_empty_rd      FIFO empty flag
//   rd_en              FIFO read strobe (combinational from m_ready / fifo_empty_rd)
//   rd_data            FIFO read data, valid RD_LATENCY cycles after rd_en
//   m_valid, m_ready   output stream handshake
//   m_data, m_last     output beat payload and end-of-frame flag
//   word_cnt           index of the current beat within its frame
module fifo_rd_stream #(
  parameter  int unsigned DATA_WIDTH = 8,
  parameter  int unsigned RD_LATENCY = 1,
  parameter  int unsigned FRAME_LEN  = 16,
  localparam int unsigned BUF_DEPTH  = RD_LATENCY + 1,
  localparam int unsigned CNT_W      = $clog2(FRAME_LEN)
) (
  input  logic                  clk_rd,
  input  logic                  rst_rd_n,
  input  logic                  fifo_empty_rd,
  output logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic [CNT_W-1:0]      word_cnt
);

  localparam int unsigned OCC_W = $clog2(BUF_DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(BUF_DEPTH);

  logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [OCC_W-1:0]      buf_occ;
  logic [RD_LATENCY-1:0] inflight_vld;
  logic [OCC_W-1:0]      inflight_cnt;
  logic [OCC_W-1:0]      credits;
  logic                  run_q;
  logic                  accept;
  logic                  push;

  // Circular pointer advance over a non-power-of-two depth.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Stream side is a pure function of the buffer registers (no rd_data bypass).
  assign m_valid = (buf_occ != '0);
  assign m_data  = mem[rd_ptr];
  assign m_last  = m_valid & (word_cnt == CNT_W'(FRAME_LEN - 1));
  assign accept  = m_valid & m_ready;
  assign push    = inflight_vld[RD_LATENCY-1];

  // Credits = entries held + reads still in the FIFO pipeline.
  always_comb begin
    inflight_cnt = '0;
    for (int i = 0; i < int'(RD_LATENCY); i++) begin
      inflight_cnt = inflight_cnt + OCC_W'(inflight_vld[i]);
    end
    credits = buf_occ + inflight_cnt;
  end

  // A slot freed by this cycle's accept may be re-issued immediately, giving
  // full throughput; m_ready only feeds rd_en, never the other way round.
  assign rd_en = run_q & ~fifo_empty_rd &
                 ((credits - OCC_W'(accept)) < OCC_W'(BUF_DEPTH));

  // Hold off reads until the first clock after reset release.
  always_ff @(posedge clk_rd or negedge rst_rd_n) begin
    if (!rst_rd_n) run_q <= 1'b0;
    else           run_q <= 1'b1;
  end

  // In-flight valid shift register, one stage per cycle of FIFO read latency.
  if (RD_LATENCY == 1) begin : g_lat1
    always_ff @(posedge clk_rd or negedge rst_rd_n) begin
      if (!rst_rd_n) inflight_vld <= '0;
      else           inflight_vld <= rd_en;
    end
  end else begin : g_latn
    always_ff @(posedge clk_rd or negedge rst_rd_n) begin
      if (!rst_rd_n) inflight_vld <= '0;
      else           inflight_vld <= {inflight_vld[RD_LATENCY-2:0], rd_en};
    end
  end

  // Skid buffer: landed read data pushed at the tail, head popped on accept.
  always_ff @(posedge clk_rd or negedge rst_rd_n) begin
    if (!rst_rd_n) begin
      for (int i = 0; i < int'(BUF_DEPTH); i++) mem[i] <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      buf_occ <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= rd_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (accept) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, accept})
        2'b10:   buf_occ <= buf_occ + OCC_W'(1);
        2'b01:   buf_occ <= buf_occ - OCC_W'(1);
        default: buf_occ <= buf_occ;
      endcase
    end
  end

  // Beat index within the frame, wrapping on the accept of the last beat.
  always_ff @(posedge clk_rd or negedge rst_rd_n) begin
    if (!rst_rd_n) begin
      word_cnt <= '0;
    end else if (accept) begin
      if (word_cnt == CNT_W'(FRAME_LEN - 1)) word_cnt <= '0;
      else                                   word_cnt <= word_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: drives fifo_rd_stream from a queue-based FIFO model with
// a fixed read latency; a scoreboard of expected beats (data, frame position)
// is filled when words are loaded and drained by an independent monitor.
module tb_fifo_rd_stream;
  localparam int unsigned DW        = 8;
  localparam int unsigned RD_LAT    = 1;
  localparam int unsigned FL        = 16;
  localparam int unsigned BUF_DEPTH = RD_LAT + 1;
  localparam int unsigned CNT_W     = $clog2(FL);

  logic             clk_rd = 1'b0;
  logic             rst_rd_n = 1'b0;
  logic             fifo_empty_rd = 1'b1;
  logic             rd_en;
  logic [DW-1:0]    rd_data = '0;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic [DW-1:0]    m_data;
  logic             m_last;
  logic [CNT_W-1:0] word_cnt;

  always #5 clk_rd = ~clk_rd;

  fifo_rd_stream #(.DATA_WIDTH(DW), .RD_LATENCY(RD_LAT), .FRAME_LEN(FL)) dut (
    .clk_rd(clk_rd), .rst_rd_n(rst_rd_n), .fifo_empty_rd(fifo_empty_rd),
    .rd_en(rd_en), .rd_data(rd_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_last(m_last), .word_cnt(word_cnt)
  );

  typedef struct packed {
    logic [DW-1:0]    data;
    logic             last;
    logic [CNT_W-1:0] cnt;
  } beat_t;

  beat_t         exp_q[$];
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] dpipe[RD_LAT];
  int            total = 0;
  int            bad = 0;
  int            exp_idx = 0;
  int            fired = 0;
  int            accepted = 0;
  logic          gate = 1'b0;
  logic          s_fire, s_acc, s_valid, s_last;
  logic [DW-1:0] s_data;
  logic [CNT_W-1:0] s_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, req);
    end
  endtask

  task automatic upd_empty();
    fifo_empty_rd = gate | (fifo_q.size() == 0);
  endtask

  // Load a word into the FIFO model; its expected frame position follows from
  // its ordinal since reset.
  task automatic load(input logic [DW-1:0] d);
    beat_t b;
    b.data = d;
    b.cnt  = CNT_W'(exp_idx % FL);
    b.last = ((exp_idx % FL) == FL - 1);
    fifo_q.push_back(d);
    exp_q.push_back(b);
    exp_idx++;
  endtask

  // One clock: sample mid-cycle, then model the FIFO just after the edge.
  task automatic step();
    @(negedge clk_rd);
    s_fire = rd_en; s_valid = m_valid; s_acc = m_valid & m_ready;
    s_data = m_data; s_cnt = word_cnt; s_last = m_last;
    if (rst_rd_n) begin
      if (fifo_empty_rd) chk("rd_en_while_empty", 32'(rd_en), 0);
      fired    += int'(s_fire);
      accepted += int'(s_acc);
      chk("outstanding_le_depth", 32'(fired - accepted <= int'(BUF_DEPTH)), 1);
    end
    @(posedge clk_rd);
    #1;
    for (int i = RD_LAT - 1; i > 0; i--) dpipe[i] = dpipe[i-1];
    if (rst_rd_n && s_fire && fifo_q.size() != 0) dpipe[0] = fifo_q.pop_front();
    else                                          dpipe[0] = DW'($urandom);
    rd_data = dpipe[RD_LAT-1];
    upd_empty();
  endtask

  // Reset with the FIFO model reset alongside; optionally preload words while held.
  task automatic reset_hold(input int preload);
    rst_rd_n = 1'b0;
    m_ready  = 1'b0;
    gate     = 1'b0;
    fifo_q.delete();
    exp_q.delete();
    exp_idx = 0; fired = 0; accepted = 0;
    for (int i = 0; i < RD_LAT; i++) dpipe[i] = '0;
    for (int i = 0; i < preload; i++) load(DW'($urandom));
    upd_empty();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_rd_en", 32'(s_fire), 0);
      chk("rst_m_valid", 32'(s_valid), 0);
      chk("rst_m_data", 32'(s_data), 0);
      chk("rst_m_last", 32'(s_last), 0);
      chk("rst_word_cnt", 32'(s_cnt), 0);
    end
    rst_rd_n = 1'b1;
    step();
    chk("release_cycle0_rd_en", 32'(s_fire), 0);
    step();
    chk("release_cycle1_rd_en", 32'(s_fire), 32'(preload > 0));
  endtask

  task automatic drain(input string name, input int maxc);
    int n;
    n = 0;
    m_ready = 1'b1;
    gate    = 1'b0;
    upd_empty();
    while ((exp_q.size() != 0 || fifo_q.size() != 0) && n < maxc) begin
      step();
      n++;
    end
    chk({name, "_drained"}, 32'(exp_q.size()), 0);
  endtask

  // Monitor: compares every accepted beat with the scoreboard and checks that
  // a stalled beat is held unchanged.
  initial begin : monitor
    beat_t         e;
    logic          prev_stall;
    logic [DW-1:0] p_data;
    logic          p_last;
    logic [CNT_W-1:0] p_cnt;
    prev_stall = 1'b0;
    p_data = '0; p_last = 1'b0; p_cnt = '0;
    forever begin
      @(negedge clk_rd);
      if (!rst_rd_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("hold_valid", 32'(m_valid), 1);
          chk("hold_data", 32'(m_data), 32'(p_data));
          chk("hold_last", 32'(m_last), 32'(p_last));
          chk("hold_cnt", 32'(word_cnt), 32'(p_cnt));
        end
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("beat_data", 32'(m_data), 32'(e.data));
            chk("beat_last", 32'(m_last), 32'(e.last));
            chk("beat_cnt", 32'(word_cnt), 32'(e.cnt));
          end
        end
        prev_stall = m_valid & ~m_ready;
        p_data = m_data; p_last = m_last; p_cnt = word_cnt;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n, n_acc, first_c, last_c, cnt_at_last, n_last, f0;

    // T1: reset with a non-empty FIFO, then drain what was preloaded
    reset_hold(8);
    drain("t1", 200);

    // T2: single word latency
    reset_hold(0);
    m_ready = 1'b1;
    load(8'hA5);
    upd_empty();
    n = 0;
    do begin step(); n++; end while (!s_fire && n < 10);
    chk("t2_fire_seen", 32'(s_fire), 1);
    step(); chk("t2_valid_t1", 32'(s_valid), 0);
    step(); chk("t2_valid_t2", 32'(s_valid), 1);
    chk("t2_data_t2", 32'(s_data), 32'h A5);
    step(); chk("t2_valid_t3", 32'(s_valid), 0);
    chk("t2_fifo_empty", 32'(fifo_empty_rd), 1);

    // T3: 40-word stream, full throughput
    reset_hold(0);
    m_ready = 1'b1;
    for (int i = 0; i < 40; i++) load(DW'(i));
    upd_empty();
    n_acc = 0; first_c = -1; last_c = -1; cnt_at_last = -1; n_last = 0;
    for (int c = 0; c < 200 && n_acc < 40; c++) begin
      step();
      if (s_acc) begin
        if (first_c < 0) first_c = c;
        last_c = c;
        n_acc++;
        if (s_last) n_last++;
        if (n_acc == 40) cnt_at_last = int'(s_cnt);
      end
    end
    chk("t3_accepts", 32'(n_acc), 40);
    chk("t3_no_gaps", 32'(last_c - first_c), 39);
    chk("t3_last_count", 32'(n_last), 2);
    chk("t3_cnt_last_word", 32'(cnt_at_last), 7);
    step();
    chk("t3_cnt_after", 32'(s_cnt), 8);

    // T4: backpressure from idle, then mid-stream
    reset_hold(0);
    m_ready = 1'b0;
    for (int i = 0; i < 30; i++) load(DW'($urandom));
    upd_empty();
    f0 = fired;
    for (int i = 0; i < 20; i++) step();
    chk("t4_fires_while_stalled", 32'(fired - f0), BUF_DEPTH);
    m_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    m_ready = 1'b0;
    for (int i = 0; i < 20; i++) step();
    chk("t4_outstanding_stalled", 32'(fired - accepted), BUF_DEPTH);
    drain("t4", 200);

    // T5: toggling empty flag with random ready
    reset_hold(0);
    for (int i = 0; i < 60; i++) load(DW'($urandom));
    for (int c = 0; c < 600 && exp_q.size() != 0; c++) begin
      gate    = ((c / 3) % 2) == 1;
      m_ready = 1'($urandom_range(0, 1));
      upd_empty();
      step();
    end
    drain("t5", 300);

    // T6: reset mid-frame, next frame restarts at beat 0
    reset_hold(0);
    m_ready = 1'b1;
    for (int i = 0; i < 20; i++) load(DW'($urandom));
    upd_empty();
    n = 0;
    while (accepted < 5 && n < 50) begin step(); n++; end
    chk("t6_five_accepts", 32'(accepted), 5);
    reset_hold(0);
    m_ready = 1'b1;
    for (int i = 0; i < 20; i++) load(DW'($urandom));
    upd_empty();
    n = 0;
    do begin step(); n++; end while (!s_acc && n < 20);
    chk("t6_first_cnt", 32'(s_cnt), 0);
    drain("t6", 200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
